// File: rtl/cpu_trace_buffer.sv
// cpu_trace_buffer
//   Circular trace recorder for the CPU, clocked by the fast board clock.
//   On every rising edge of the human clock (sample_clk) while armed, it
//   records {supervisor, pc, acc, opcode, opdata}. A trigger sample, followed
//   by POST_SAMPLES more samples, freezes the history. The user then steps
//   through it, oldest entry first, with browse_step.
//
// Ports
//   CLK          board clock; all state updates on its rising edge
//   reset        asynchronous, active-high; clears all state
//   sample_clk   human clock level (CLK domain); a rising edge is a sample tick
//   arm          1 = capture enabled; 0 aborts back to IDLE
//   trigger      sampled only on ticks while recording
//   browse_step  rising edge advances the browse index while frozen
//   pc/acc/opcode/opdata/supervisor  live CPU state
//   number_out   registered display word (live fields, or the browsed entry)
//   state_out    00 IDLE, 01 RECORD, 10 POST, 11 FROZEN
//   count_out    number of valid entries; saturates at DEPTH
//   frozen_led   high while in FROZEN
//
// state  | meaning
// IDLE   | not capturing; arm=1 starts a fresh recording
// RECORD | writing one entry per tick; watching for the trigger
// POST   | writing the post-trigger samples; trigger is ignored
// FROZEN | no writes; browse_step walks the history, oldest entry first
module cpu_trace_buffer #(
  parameter int DEPTH        = 16,
  parameter int ADDR_W       = 4,
  parameter int PC_W         = 6,
  parameter int POST_SAMPLES = 4
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              sample_clk,
  input  logic              arm,
  input  logic              trigger,
  input  logic              browse_step,
  input  logic [PC_W-1:0]   pc,
  input  logic [3:0]        acc,
  input  logic [3:0]        opcode,
  input  logic [3:0]        opdata,
  input  logic              supervisor,
  output logic [31:0]       number_out,
  output logic [1:0]        state_out,
  output logic [ADDR_W:0]   count_out,
  output logic              frozen_led
);

  localparam int EW = PC_W + 13;
  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] POST_C  = ADDR_W'(POST_SAMPLES);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RECORD = 2'b01,
    POST   = 2'b10,
    FROZEN = 2'b11
  } state_t;

  state_t            state;
  logic              sample_q;
  logic              step_q;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_idx;
  logic [ADDR_W-1:0] post_cnt;
  logic [ADDR_W:0]   count;

  logic [EW-1:0]     mem [DEPTH];

  logic              tick;
  logic              bstep;
  logic              wr_en;
  logic              full;
  logic [ADDR_W:0]   count_nxt;
  logic [ADDR_W:0]   count_m1;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] rd_addr;
  logic [EW-1:0]     live_entry;
  logic [EW-1:0]     src_entry;
  logic [ADDR_W-1:0] src_idx;
  logic [PC_W-1:0]   src_pc;
  logic [31:0]       word;

  assign tick  = sample_clk & ~sample_q;
  assign bstep = browse_step & ~step_q;
  // A tick in the same cycle that arm drops is discarded.
  assign wr_en = tick & arm & ((state == RECORD) || (state == POST));

  always_comb begin
    live_entry = {supervisor, pc, acc, opcode, opdata};
    full       = (count == DEPTH_C);
    count_nxt  = full ? count : count + CNT_ONE;
    count_m1   = count - CNT_ONE;
    // Until the buffer has wrapped, the oldest entry sits at address 0;
    // afterwards it is the slot about to be overwritten next.
    base       = full ? wr_ptr : '0;
    rd_addr    = base + rd_idx;
    if (state == FROZEN) begin
      src_entry = mem[rd_addr];
      src_idx   = rd_idx;
    end else begin
      src_entry = live_entry;
      src_idx   = wr_ptr;
    end
    src_pc = src_entry[EW-2 -: PC_W];
    word   = {8'(src_pc), 4'(src_idx), src_entry[11:8],
              3'b000, src_entry[EW-1], src_entry[7:4],
              4'b0000, src_entry[3:0]};
  end

  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem[wr_ptr] <= live_entry;
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      sample_q   <= 1'b0;
      step_q     <= 1'b0;
      wr_ptr     <= '0;
      rd_idx     <= '0;
      post_cnt   <= '0;
      count      <= '0;
      number_out <= '0;
      frozen_led <= 1'b0;
    end else begin
      sample_q   <= sample_clk;
      step_q     <= browse_step;
      number_out <= word;
      case (state)
        IDLE: begin
          if (arm) begin
            state  <= RECORD;
            wr_ptr <= '0;
            count  <= '0;
          end
        end
        RECORD: begin
          if (!arm) begin
            state <= IDLE;
          end else if (tick) begin
            wr_ptr <= wr_ptr + PTR_ONE;
            count  <= count_nxt;
            if (trigger) begin
              if (POST_SAMPLES == 0) begin
                state      <= FROZEN;
                rd_idx     <= '0;
                frozen_led <= 1'b1;
              end else begin
                state    <= POST;
                post_cnt <= POST_C;
              end
            end
          end
        end
        POST: begin
          if (!arm) begin
            state <= IDLE;
          end else if (tick) begin
            wr_ptr   <= wr_ptr + PTR_ONE;
            count    <= count_nxt;
            post_cnt <= post_cnt - PTR_ONE;
            if (post_cnt == PTR_ONE) begin
              state      <= FROZEN;
              rd_idx     <= '0;
              frozen_led <= 1'b1;
            end
          end
        end
        FROZEN: begin
          if (!arm) begin
            state      <= IDLE;
            frozen_led <= 1'b0;
          end else if (bstep) begin
            rd_idx <= ((ADDR_W+1)'(rd_idx) == count_m1) ? '0 : rd_idx + PTR_ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign state_out = state;
  assign count_out = count;

endmodule

// File: tb/tb_cpu_trace_buffer.sv
module tb_cpu_trace_buffer;

  logic        CLK = 1'b0;
  logic        reset = 1'b0;
  logic        sample_clk = 1'b0;
  logic        arm = 1'b0;
  logic        trigger = 1'b0;
  logic        browse_step = 1'b0;
  logic [5:0]  pc = '0;
  logic [3:0]  acc = '0;
  logic [3:0]  opcode = '0;
  logic [3:0]  opdata = '0;
  logic        supervisor = 1'b0;

  logic [31:0] n0, n4;
  logic [1:0]  s0, s4;
  logic [4:0]  c0, c4;
  logic        f0, f4;

  int total = 0;
  int bad = 0;

  logic [18:0] q0[$];
  logic [18:0] q4[$];

  cpu_trace_buffer #(.DEPTH(16), .ADDR_W(4), .PC_W(6), .POST_SAMPLES(0)) dut0 (
    .CLK(CLK), .reset(reset), .sample_clk(sample_clk), .arm(arm),
    .trigger(trigger), .browse_step(browse_step), .pc(pc), .acc(acc),
    .opcode(opcode), .opdata(opdata), .supervisor(supervisor),
    .number_out(n0), .state_out(s0), .count_out(c0), .frozen_led(f0)
  );

  cpu_trace_buffer #(.DEPTH(16), .ADDR_W(4), .PC_W(6), .POST_SAMPLES(4)) dut4 (
    .CLK(CLK), .reset(reset), .sample_clk(sample_clk), .arm(arm),
    .trigger(trigger), .browse_step(browse_step), .pc(pc), .acc(acc),
    .opcode(opcode), .opdata(opdata), .supervisor(supervisor),
    .number_out(n4), .state_out(s4), .count_out(c4), .frozen_led(f4)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [31:0] mk_word(input logic [18:0] e, input logic [3:0] idx);
    return {2'b00, e[17:12], idx, e[11:8], 3'b000, e[18], e[7:4], 4'b0000, e[3:0]};
  endfunction

  // One sample tick: sample_clk high for one CLK cycle, then low.
  task automatic do_tick(input logic [5:0] p, input logic trg, output logic [18:0] e);
    @(negedge CLK);
    pc         = p;
    acc        = 4'($urandom_range(0, 15));
    opcode     = 4'($urandom_range(0, 15));
    opdata     = 4'($urandom_range(0, 15));
    supervisor = 1'($urandom_range(0, 1));
    trigger    = trg;
    sample_clk = 1'b1;
    e = {supervisor, pc, acc, opcode, opdata};
    @(negedge CLK);
    sample_clk = 1'b0;
    trigger    = 1'b0;
  endtask

  task automatic do_step();
    @(negedge CLK);
    browse_step = 1'b1;
    @(negedge CLK);
    browse_step = 1'b0;
    @(negedge CLK);
  endtask

  task automatic rearm();
    @(negedge CLK);
    arm = 1'b0;
    @(negedge CLK);
    arm = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_reset();
    logic [18:0] e;
    #1 reset = 1'b1;
    #2;
    total++; if (s0 !== 2'b00) begin bad++; $display("FAIL reset_state: got %b want 00", s0); end
    total++; if (n0 !== 32'h0) begin bad++; $display("FAIL reset_number: got %h want 0", n0); end
    total++; if (c0 !== 5'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", c0); end
    total++; if (f0 !== 1'b0) begin bad++; $display("FAIL reset_led: got %b want 0", f0); end
    @(negedge CLK);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      do_tick(6'(10 + i), 1'b0, e);
      total++; if (s0 !== 2'b00 || s4 !== 2'b00) begin bad++; $display("FAIL idle_state: got %b/%b want 00", s0, s4); end
      total++; if (c0 !== 5'd0) begin bad++; $display("FAIL idle_count: got %0d want 0", c0); end
      total++; if (n0 !== mk_word(e, 4'd0)) begin bad++; $display("FAIL idle_live: got %h want %h", n0, mk_word(e, 4'd0)); end
    end
  endtask

  task automatic test_basic();
    logic [18:0] e;
    rearm();
    q0.delete();
    for (int t = 1; t <= 3; t++) begin
      do_tick(6'(t), t == 3, e);
      q0.push_back(e);
    end
    total++; if (s0 !== 2'b11) begin bad++; $display("FAIL basic_state: got %b want 11", s0); end
    total++; if (f0 !== 1'b1) begin bad++; $display("FAIL basic_led: got %b want 1", f0); end
    total++; if (c0 !== 5'd3) begin bad++; $display("FAIL basic_count: got %0d want 3", c0); end
    @(negedge CLK);
    total++; if (n0[31:24] !== 8'h01) begin bad++; $display("FAIL basic_first_pc: got %h want 01", n0[31:24]); end
    for (int i = 0; i < 3; i++) begin
      e = q0.pop_front();
      total++; if (n0 !== mk_word(e, 4'(i))) begin bad++; $display("FAIL basic_browse%0d: got %h want %h", i, n0, mk_word(e, 4'(i))); end
      q0.push_back(e);
      do_step();
    end
    e = q0[0];
    total++; if (n0 !== mk_word(e, 4'd0)) begin bad++; $display("FAIL basic_wrap: got %h want %h", n0, mk_word(e, 4'd0)); end
  endtask

  task automatic test_post();
    logic [18:0] e;
    logic [1:0]  want;
    rearm();
    q4.delete();
    for (int t = 1; t <= 6; t++) begin
      do_tick(6'(20 + t), (t == 2) || (t == 4), e);
      q4.push_back(e);
      want = (t < 2) ? 2'b01 : (t < 6) ? 2'b10 : 2'b11;
      total++; if (s4 !== want) begin bad++; $display("FAIL post_state%0d: got %b want %b", t, s4, want); end
    end
    total++; if (c4 !== 5'd6) begin bad++; $display("FAIL post_count: got %0d want 6", c4); end
    total++; if (f4 !== 1'b1) begin bad++; $display("FAIL post_led: got %b want 1", f4); end
    @(negedge CLK);
    for (int i = 0; i < 6; i++) begin
      e = q4.pop_front();
      total++; if (n4 !== mk_word(e, 4'(i))) begin bad++; $display("FAIL post_browse%0d: got %h want %h", i, n4, mk_word(e, 4'(i))); end
      if (i < 5) do_step();
    end
  endtask

  task automatic test_wrap();
    logic [18:0] e;
    rearm();
    q0.delete();
    for (int t = 0; t < 20; t++) begin
      do_tick(6'(t), t == 19, e);
      q0.push_back(e);
      if (q0.size() > 16) void'(q0.pop_front());
    end
    total++; if (c0 !== 5'd16) begin bad++; $display("FAIL wrap_count: got %0d want 16", c0); end
    total++; if (s0 !== 2'b11) begin bad++; $display("FAIL wrap_state: got %b want 11", s0); end
    @(negedge CLK);
    total++; if (n0[31:24] !== 8'd4) begin bad++; $display("FAIL wrap_oldest_pc: got %0d want 4", n0[31:24]); end
    for (int i = 0; i < 16; i++) begin
      e = q0.pop_front();
      total++; if (n0 !== mk_word(e, 4'(i))) begin bad++; $display("FAIL wrap_browse%0d: got %h want %h", i, n0, mk_word(e, 4'(i))); end
      q0.push_back(e);
      if (i == 15) begin
        total++; if (n0[31:24] !== 8'd19) begin bad++; $display("FAIL wrap_newest_pc: got %0d want 19", n0[31:24]); end
      end
      do_step();
    end
    e = q0[0];
    total++; if (n0 !== mk_word(e, 4'd0)) begin bad++; $display("FAIL wrap_index_wrap: got %h want %h", n0, mk_word(e, 4'd0)); end
  endtask

  task automatic test_abort();
    logic [18:0] e;
    rearm();
    do_tick(6'd33, 1'b1, e);
    total++; if (s4 !== 2'b10) begin bad++; $display("FAIL abort_pre_state: got %b want 10", s4); end
    @(negedge CLK);
    arm        = 1'b0;
    pc         = 6'd40;
    sample_clk = 1'b1;
    @(negedge CLK);
    sample_clk = 1'b0;
    total++; if (s4 !== 2'b00) begin bad++; $display("FAIL abort_state: got %b want 00", s4); end
    total++; if (c4 !== 5'd1) begin bad++; $display("FAIL abort_count: got %0d want 1", c4); end
    @(negedge CLK);
    total++; if (n4[23:20] !== 4'd1) begin bad++; $display("FAIL abort_wrptr: got %0d want 1", n4[23:20]); end
    total++; if (n4[31:24] !== 8'd40) begin bad++; $display("FAIL abort_live_pc: got %0d want 40", n4[31:24]); end
    arm = 1'b1;
    @(negedge CLK);
    total++; if (s4 !== 2'b01) begin bad++; $display("FAIL rearm_state: got %b want 01", s4); end
    total++; if (c4 !== 5'd0) begin bad++; $display("FAIL rearm_count: got %0d want 0", c4); end
    @(negedge CLK);
    total++; if (n4[23:20] !== 4'd0) begin bad++; $display("FAIL rearm_wrptr: got %0d want 0", n4[23:20]); end
  endtask

  task automatic test_async_reset();
    logic [18:0] e;
    rearm();
    do_tick(6'd7, 1'b1, e);
    @(negedge CLK);
    total++; if (f0 !== 1'b1 || n0 !== mk_word(e, 4'd0)) begin bad++; $display("FAIL areset_pre: got led %b word %h want 1 %h", f0, n0, mk_word(e, 4'd0)); end
    #2 reset = 1'b1;
    #1;
    total++; if (s0 !== 2'b00) begin bad++; $display("FAIL areset_state: got %b want 00", s0); end
    total++; if (n0 !== 32'h0) begin bad++; $display("FAIL areset_number: got %h want 0", n0); end
    total++; if (f0 !== 1'b0) begin bad++; $display("FAIL areset_led: got %b want 0", f0); end
    total++; if (c0 !== 5'd0) begin bad++; $display("FAIL areset_count: got %0d want 0", c0); end
    @(negedge CLK);
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_post();
    test_wrap();
    test_abort();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu_trace_buffer.md
Name: cpu_trace_buffer

Overview:
- Circular trace recorder downstream of the CPU, in the fast board clock domain.
- Samples CPU architectural state (PC, A, opcode, opdata, supervisor) on every human-clock rising edge.
- Stops recording a programmable number of samples after a trigger, such as an error or a malware-activation opcode.
- Lets the user step through the frozen history; its 32-bit number_out drives the 7-segment display in place of the live CPU fields.

Parameters:
- DEPTH, 16, number of trace entries (power of two).
- ADDR_W, 4, log2(DEPTH).
- PC_W, 6, PC width.
- POST_SAMPLES, 4, samples recorded after the trigger sample before freezing (0..DEPTH-1).

Ports:
- CLK  in  1  board clock; all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- sample_clk  in  1  human clock, a registered signal in the CLK domain; rising edge = sample tick.
- arm  in  1  level, debounced; 1 = capture enabled.
- trigger  in  1  level; evaluated only on sample ticks.
- browse_step  in  1  level, debounced; rising edge advances browse index.
- pc  in  PC_W  CPU PC.
- acc  in  4  CPU A[3:0].
- opcode  in  4  CPU opcode.
- opdata  in  4  CPU opdata.
- supervisor  in  1  CPU supervisor flag.
- number_out  out  32  display word.
- state_out  out  2  00 IDLE, 01 RECORD, 10 POST, 11 FROZEN.
- count_out  out  ADDR_W+1  valid entries, saturates at DEPTH.
- frozen_led  out  1  state==FROZEN.

Behaviour:
- Edge detection: sample_q and step_q hold the previous values of sample_clk and browse_step.
  - tick = sample_clk & ~sample_q.
  - bstep = browse_step & ~step_q.
- Capture: inputs are captured combinationally in the tick cycle, i.e. the CPU state after its clock edge. The entry is written at wr_ptr on that same CLK edge.
- Entry format: {supervisor, pc, acc, opcode, opdata}.
- Reset values:
  - State: IDLE.
  - wr_ptr, count, rd_idx, post_cnt: 0.
  - number_out: 0, registered.
  - frozen_led: 0.
  - sample_q, step_q: 0.
  - Memory contents: don't-care.
- IDLE:
  - No writes.
  - arm=1 -> RECORD, with wr_ptr=0 and count=0 in the same cycle.
- RECORD:
  - On each tick: write, wr_ptr increments modulo DEPTH, count increments and saturates at DEPTH.
  - If trigger=1 on that tick: the trigger sample is written. If POST_SAMPLES=0 -> FROZEN; else -> POST with post_cnt=POST_SAMPLES.
- POST:
  - Each tick writes an entry and decrements post_cnt; trigger is ignored.
  - The tick that writes with post_cnt==1 -> FROZEN.
- FROZEN:
  - No writes.
  - On entry, rd_idx=0, which selects the oldest entry.
  - base = 0 if count<DEPTH, else wr_ptr.
  - Physical read address = (base + rd_idx) mod DEPTH.
  - bstep: rd_idx = (rd_idx == count-1) ? 0 : rd_idx+1.
  - bstep outside FROZEN is ignored.
- Abort/rearm:
  - arm=0 in RECORD, POST or FROZEN -> IDLE next cycle. Any tick or bstep in that same cycle is ignored.
  - Recording restarts only after the next arm=1 cycle in IDLE.
- number_out, registered one cycle after its source:
  - [31:24] = {2'b00, pc}
  - [23:20] = index
  - [19:16] = acc
  - [15:12] = {3'b000, supervisor}
  - [11:8] = opcode
  - [7:4] = 0
  - [3:0] = opdata
- Source fields by state:
  - FROZEN: taken from the selected entry; index = rd_idx.
  - Other states: live inputs; index = wr_ptr.
- Reset asserted mid-capture: immediate return to IDLE. Outputs go to their reset values asynchronously.
- count==DEPTH with continued ticks: the oldest entry is overwritten and count stays at DEPTH.

Test Plan:
- Reset/idle: reset, then 5 ticks with arm=0 -> state_out=00, count_out=0; number_out tracks live inputs with index field 0.
- Basic capture: arm=1; 3 ticks with pc=1,2,3; trigger=1 on tick 3; POST_SAMPLES=0 -> FROZEN. number_out[31:24]=01, index 0. Two bsteps -> pc 03. A third bstep wraps to pc 01.
- Post-trigger: POST_SAMPLES=4; trigger on tick 2 -> state 10 for 4 further ticks, FROZEN after tick 6, count_out=6; the last entry holds tick 6 data.
- Wrap: 20 ticks with pc=0..19, then trigger on tick 20 -> count_out=16; rd_idx 0 shows pc=4, rd_idx 15 shows pc=19.
- Abort: drop arm during POST with a simultaneous tick -> IDLE next cycle, no write. Re-arm -> count_out=0.
- Async reset mid-FROZEN, asserted between CLK edges -> state_out=00, number_out=0 and frozen_led=0 immediately.
